// File: rtl/mips_pkg.sv
// mips_pkg: shared word/entry types and default store-buffer depth.
package mips_pkg;
    typedef logic [31:0] word_t;
    typedef struct packed {
        word_t addr;
        word_t data;
    } sb_entry_t;
    localparam int SB_DEPTH = 4;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: compares a load address against every valid entry and
// returns the data of the youngest match (closest to tail).
module sb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [PTR_W-1:0]             tail_i,
    input  logic [ADDR_W-1:0]            ld_addr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);
    logic [PTR_W-1:0] idx;

    // Walk backwards from the newest entry; the first match is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail_i - PTR_W'(k + 1);
            if (!hit_o && valid_i[idx] && addr_i[idx] == ld_addr_i) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write queue draining into data_memory when no load uses the port.
// Forwarding to loads is compiled in with STORE_BUFFER_FWD_EN; otherwise a matching load stalls stores.
module store_buffer import mips_pkg::*; #(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ready,
    input  logic                         ld_valid,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         drain_req,
    output logic                         drained,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d, off;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DEPTH-1:0]             valid;
    logic                         push, pop, match_hit, unused_drain_req;
    logic [DATA_W-1:0]            match_data;

    assign unused_drain_req = drain_req;
    assign pop       = (count_q != '0) && !ld_valid;
    assign push      = st_valid && st_ready;
    assign mem_write = pop;
    assign mem_addr  = (count_q != '0) ? addr_q[head_q] : '0;
    assign mem_wdata = (count_q != '0) ? data_q[head_q] : '0;
    assign drained   = count_q == '0;
    assign count     = count_q;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        off   = '0;
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - head_q;
            valid[i] = CNT_W'(off) < count_q;
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match (
        .addr_i    (addr_q),
        .data_i    (data_q),
        .valid_i   (valid),
        .tail_i    (tail_q),
        .ld_addr_i (ld_addr),
        .hit_o     (match_hit),
        .data_o    (match_data)
    );

`ifdef STORE_BUFFER_FWD_EN
    assign st_ready = count_q != CNT_W'(DEPTH);
    assign fwd_hit  = match_hit;
    assign fwd_data = match_data;
`else
    logic unused_match_data;
    assign unused_match_data = ^match_data;
    assign st_ready = (count_q != CNT_W'(DEPTH)) && !(ld_valid && match_hit);
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_comb begin
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven checks of store_buffer plus reset sequences.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, ld_valid, drain_req;
    logic [31:0] st_addr, st_data, ld_addr;
    logic        st_ready, fwd_hit, mem_write, drained;
    logic [31:0] fwd_data, mem_addr, mem_wdata;
    logic [2:0]  count;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic        sv;
        logic [31:0] sa, sd;
        logic        lv;
        logic [31:0] la;
        logic        dr;
        logic [2:0]  cnt;
        logic        rdy, mw;
        logic [31:0] ma, md;
        logic        fh;
        logic [31:0] fd;
        logic        dn;
    } vec_t;

    vec_t tv[22];

    store_buffer dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .drain_req(drain_req), .drained(drained), .count(count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd, logic lv,
                                logic [31:0] la, logic dr, logic [2:0] cnt, logic rdy,
                                logic mw, logic [31:0] ma, logic [31:0] md, logic fh,
                                logic [31:0] fd, logic dn);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.dr = dr;
        v.cnt = cnt; v.rdy = rdy; v.mw = mw; v.ma = ma; v.md = md;
        v.fh = fh; v.fd = fd; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic dr);
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; drain_req = dr;
    endtask

    initial begin
        // fh/fd describe the youngest matching entry; without forwarding they become the stall hint.
        tv[0]  = mk(1, 32'h10, 32'hDEADBEEF, 0, 32'h0,  0, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);
        tv[1]  = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
        tv[2]  = mk(0, 32'h0,  32'h0,        0, 32'h0,  1, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);
        tv[3]  = mk(1, 32'h20, 32'h1,        1, 32'h20, 0, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);
        tv[4]  = mk(1, 32'h20, 32'h2,        1, 32'h99, 0, 1, 1, 0, 32'h20, 32'h1,        0, 32'h0, 0);
        tv[5]  = mk(0, 32'h0,  32'h0,        1, 32'h20, 0, 2, 1, 0, 32'h20, 32'h1,        1, 32'h2, 0);
        tv[6]  = mk(0, 32'h0,  32'h0,        1, 32'h21, 0, 2, 1, 0, 32'h20, 32'h1,        0, 32'h0, 0);
        tv[7]  = mk(0, 32'h0,  32'h0,        0, 32'h20, 0, 2, 1, 1, 32'h20, 32'h1,        1, 32'h2, 0);
        tv[8]  = mk(0, 32'h0,  32'h0,        1, 32'h20, 0, 1, 1, 0, 32'h20, 32'h2,        1, 32'h2, 0);
        tv[9]  = mk(0, 32'h0,  32'h0,        0, 32'h20, 0, 1, 1, 1, 32'h20, 32'h2,        1, 32'h2, 0);
        tv[10] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);
        tv[11] = mk(1, 32'h1,  32'h101,      1, 32'h0,  0, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);
        tv[12] = mk(1, 32'h2,  32'h102,      1, 32'h0,  0, 1, 1, 0, 32'h1,  32'h101,      0, 32'h0, 0);
        tv[13] = mk(1, 32'h3,  32'h103,      1, 32'h0,  0, 2, 1, 0, 32'h1,  32'h101,      0, 32'h0, 0);
        tv[14] = mk(1, 32'h4,  32'h104,      1, 32'h0,  0, 3, 1, 0, 32'h1,  32'h101,      0, 32'h0, 0);
        tv[15] = mk(1, 32'h5,  32'h105,      1, 32'h0,  0, 4, 0, 0, 32'h1,  32'h101,      0, 32'h0, 0);
        tv[16] = mk(1, 32'h5,  32'h105,      0, 32'h0,  0, 4, 0, 1, 32'h1,  32'h101,      0, 32'h0, 0);
        tv[17] = mk(1, 32'h5,  32'h105,      0, 32'h0,  0, 3, 1, 1, 32'h2,  32'h102,      0, 32'h0, 0);
        tv[18] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 3, 1, 1, 32'h3,  32'h103,      0, 32'h0, 0);
        tv[19] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 2, 1, 1, 32'h4,  32'h104,      0, 32'h0, 0);
        tv[20] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 1, 1, 1, 32'h5,  32'h105,      0, 32'h0, 0);
        tv[21] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0, 0, 1, 0, 32'h0,  32'h0,        0, 32'h0, 1);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.st_ready", 32'(st_ready), 32'd1);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst.fwd_data", fwd_data, 32'd0);
        chk("rst.drained", 32'(drained), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        for (int i = 0; i < 22; i++) begin
            logic exp_rdy, exp_fh;
            logic [31:0] exp_fd;
`ifdef STORE_BUFFER_FWD_EN
            exp_rdy = tv[i].rdy;
            exp_fh  = tv[i].fh;
            exp_fd  = tv[i].fd;
`else
            exp_rdy = tv[i].rdy && !(tv[i].lv && tv[i].fh);
            exp_fh  = 1'b0;
            exp_fd  = 32'h0;
`endif
            drive(tv[i].sv, tv[i].sa, tv[i].sd, tv[i].lv, tv[i].la, tv[i].dr);
            #1;
            chk($sformatf("v%0d.count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("v%0d.st_ready", i), 32'(st_ready), 32'(exp_rdy));
            chk($sformatf("v%0d.mem_write", i), 32'(mem_write), 32'(tv[i].mw));
            chk($sformatf("v%0d.mem_addr", i), mem_addr, tv[i].ma);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, tv[i].md);
            chk($sformatf("v%0d.fwd_hit", i), 32'(fwd_hit), 32'(exp_fh));
            chk($sformatf("v%0d.fwd_data", i), fwd_data, exp_fd);
            chk($sformatf("v%0d.drained", i), 32'(drained), 32'(tv[i].dn));
            @(posedge clk) #1;
        end

        // Async reset with three stores queued must discard them without writing.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(7 + i), 32'(32'h700 + i), 1, 32'h0, 0);
            @(posedge clk) #1;
        end
        drive(0, 0, 0, 1, 32'h7, 0);
        chk("pre_rst.count", 32'(count), 32'd3);
        chk("pre_rst.mem_write", 32'(mem_write), 32'd0);
        #2;
        ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst.count", 32'(count), 32'd0);
        chk("async_rst.mem_write", 32'(mem_write), 32'd0);
        chk("async_rst.st_ready", 32'(st_ready), 32'd1);
        chk("async_rst.drained", 32'(drained), 32'd1);
        chk("async_rst.fwd_hit", 32'(fwd_hit), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            chk($sformatf("post_rst%0d.mem_write", i), 32'(mem_write), 32'd0);
            chk($sformatf("post_rst%0d.count", i), 32'(count), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
